// File: rtl/ac97_frame_ctrl.sv
// ac97_frame_ctrl
//   System-clock front end for the ac97 frame assembler. Each rising edge of
//   ac97_ready (resynchronised) becomes one frame tick. On every tick the block
//   issues one codec register write, hands over one stereo playback sample and
//   captures one stereo record sample. After WAIT_FRAMES ticks of codec settle
//   time, a 6-entry init list is written, then the same list is refreshed
//   continuously so volume/source changes reach the codec within 6 ticks.
//
//   Optional feature macro: AC97_LOOPBACK_EN adds the loopback input, which
//   routes the record sample straight back to playback while high.
//
// Ports
//   clock, reset                    system clock, async active-high reset
//   ac97_ready                      frame ready from ac97 (asynchronous here)
//   volume, source                  master/headphone volume (31 = loudest), rec select
//   out_left, out_right             playback samples from the datapath
//   left_in_data, right_in_data     record samples from ac97
//   loopback                        (AC97_LOOPBACK_EN only) record -> playback
//   command_address/data/valid      codec register write to ac97
//   left_data, right_data, *_valid  playback slot data to ac97
//   in_left, in_right               captured record samples
//   sample_strobe                   1-cycle pulse per tick
//   init_done                       high once the init list has been issued
module ac97_frame_ctrl #(
  parameter int unsigned WAIT_FRAMES = 16,
  parameter logic [4:0]  PCM_ATTEN   = 5'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ac97_ready,
  input  logic [4:0]  volume,
  input  logic        source,
  input  logic [19:0] out_left,
  input  logic [19:0] out_right,
  input  logic [19:0] left_in_data,
  input  logic [19:0] right_in_data,
`ifdef AC97_LOOPBACK_EN
  input  logic        loopback,
`endif
  output logic [7:0]  command_address,
  output logic [15:0] command_data,
  output logic        command_valid,
  output logic [19:0] left_data,
  output logic [19:0] right_data,
  output logic        left_valid,
  output logic        right_valid,
  output logic [19:0] in_left,
  output logic [19:0] in_right,
  output logic        sample_strobe,
  output logic        init_done
);

  typedef enum logic [1:0] {S_WAIT, S_INIT, S_RUN} state_t;

  localparam int unsigned CW = $clog2(WAIT_FRAMES + 1);

  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic [2:0]    cmd_idx;
  logic [2:0]    next_idx;
  logic          ready_s1, ready_s2, ready_s3;
  logic          tick;
  logic [4:0]    atten;
  logic [15:0]   vol_data;
  logic [7:0]    cmd_addr_c;
  logic [15:0]   cmd_data_c;
  logic [19:0]   play_left_c, play_right_c;

  // Synchroniser and edge detector preset to 1: a ready level that is already
  // high when reset releases does not look like a rising edge, so ticks that
  // arrive during reset are lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_s1 <= 1'b1;
      ready_s2 <= 1'b1;
      ready_s3 <= 1'b1;
    end else begin
      ready_s1 <= ac97_ready;
      ready_s2 <= ready_s1;
      ready_s3 <= ready_s2;
    end
  end

  assign tick = ready_s2 & ~ready_s3;

  // Volume fields are attenuation; volume 0 sets the mute bit instead.
  always_comb begin
    atten    = 5'd31 - volume;
    vol_data = (volume == '0) ? 16'h8000 : {3'b000, atten, 3'b000, atten};
  end

  always_comb begin
    cmd_addr_c = 8'h02;
    cmd_data_c = vol_data;
    case (cmd_idx)
      3'd0: begin cmd_addr_c = 8'h02; cmd_data_c = vol_data; end
      3'd1: begin cmd_addr_c = 8'h04; cmd_data_c = vol_data; end
      3'd2: begin cmd_addr_c = 8'h18; cmd_data_c = {3'b000, PCM_ATTEN, 3'b000, PCM_ATTEN}; end
      3'd3: begin cmd_addr_c = 8'h1A; cmd_data_c = source ? 16'h0404 : 16'h0000; end
      3'd4: begin cmd_addr_c = 8'h1C; cmd_data_c = 16'h0F0F; end
      3'd5: begin cmd_addr_c = 8'h0E; cmd_data_c = 16'h0008; end
      default: begin cmd_addr_c = 8'h02; cmd_data_c = vol_data; end
    endcase
  end

  assign next_idx = (cmd_idx == 3'd5) ? 3'd0 : cmd_idx + 3'd1;

  always_comb begin
    play_left_c  = out_left;
    play_right_c = out_right;
`ifdef AC97_LOOPBACK_EN
    if (loopback) begin
      play_left_c  = left_in_data;
      play_right_c = right_in_data;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_WAIT;
      frame_cnt       <= '0;
      cmd_idx         <= '0;
      command_address <= '0;
      command_data    <= '0;
      command_valid   <= 1'b0;
      left_data       <= '0;
      right_data      <= '0;
      left_valid      <= 1'b0;
      right_valid     <= 1'b0;
      in_left         <= '0;
      in_right        <= '0;
      sample_strobe   <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      sample_strobe <= tick;
      if (tick) begin
        in_left    <= left_in_data;
        in_right   <= right_in_data;
        left_data  <= play_left_c;
        right_data <= play_right_c;
        case (state)
          S_WAIT: begin
            // WAIT_FRAMES full silent ticks precede the tick carrying cmd 0.
            if (frame_cnt == CW'(WAIT_FRAMES)) begin
              command_address <= cmd_addr_c;
              command_data    <= cmd_data_c;
              command_valid   <= 1'b1;
              cmd_idx         <= next_idx;
              state           <= S_INIT;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
          S_INIT: begin
            command_address <= cmd_addr_c;
            command_data    <= cmd_data_c;
            command_valid   <= 1'b1;
            cmd_idx         <= next_idx;
            if (cmd_idx == 3'd5) begin
              init_done   <= 1'b1;
              left_valid  <= 1'b1;
              right_valid <= 1'b1;
              state       <= S_RUN;
            end
          end
          S_RUN: begin
            command_address <= cmd_addr_c;
            command_data    <= cmd_data_c;
            command_valid   <= 1'b1;
            cmd_idx         <= next_idx;
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_frame_ctrl.sv
module tb_ac97_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ac97_ready;
  logic [4:0]  volume;
  logic        source;
  logic [19:0] out_left, out_right, left_in_data, right_in_data;
`ifdef AC97_LOOPBACK_EN
  logic        loopback;
`endif
  logic [7:0]  command_address;
  logic [15:0] command_data;
  logic        command_valid;
  logic [19:0] left_data, right_data, in_left, in_right;
  logic        left_valid, right_valid, sample_strobe, init_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  init_addr [6];
  logic [15:0] init_data [6];

  always #5 clock = ~clock;

  ac97_frame_ctrl dut (
    .clock(clock), .reset(reset), .ac97_ready(ac97_ready),
    .volume(volume), .source(source),
    .out_left(out_left), .out_right(out_right),
    .left_in_data(left_in_data), .right_in_data(right_in_data),
`ifdef AC97_LOOPBACK_EN
    .loopback(loopback),
`endif
    .command_address(command_address), .command_data(command_data),
    .command_valid(command_valid),
    .left_data(left_data), .right_data(right_data),
    .left_valid(left_valid), .right_valid(right_valid),
    .in_left(in_left), .in_right(in_right),
    .sample_strobe(sample_strobe), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},   {24'd0, command_address}, 32'd0);
    chk({tag, "_data"},   {16'd0, command_data}, 32'd0);
    chk({tag, "_cvalid"}, {31'd0, command_valid}, 32'd0);
    chk({tag, "_ldata"},  {12'd0, left_data}, 32'd0);
    chk({tag, "_rdata"},  {12'd0, right_data}, 32'd0);
    chk({tag, "_lvalid"}, {31'd0, left_valid}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, right_valid}, 32'd0);
    chk({tag, "_inl"},    {12'd0, in_left}, 32'd0);
    chk({tag, "_inr"},    {12'd0, in_right}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, sample_strobe}, 32'd0);
    chk({tag, "_idone"},  {31'd0, init_done}, 32'd0);
  endtask

  // One ready pulse: strobe must appear exactly on the 3rd edge after the rise,
  // and only once however long ready stays high. Returns at end of frame.
  task automatic do_tick(input int hold);
    int nstb;
    @(posedge clock); #1 ac97_ready = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      chk("strobe_early", {31'd0, sample_strobe}, 32'd0);
    end
    @(posedge clock); #1;
    chk("strobe", {31'd0, sample_strobe}, 32'd1);
    nstb = 0;
    repeat (hold) begin
      @(posedge clock); #1;
      if (sample_strobe) nstb++;
    end
    chk("strobe_single", nstb, 0);
    ac97_ready = 1'b0;
    repeat (12) @(posedge clock);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_cvalid"}, {31'd0, command_valid}, 32'd1);
    chk({tag, "_addr"}, {24'd0, command_address}, {24'd0, a});
    chk({tag, "_data"}, {16'd0, command_data}, {16'd0, d});
  endtask

  initial begin
    int nstb;
    init_addr = '{8'h02, 8'h04, 8'h18, 8'h1A, 8'h1C, 8'h0E};
    init_data = '{16'h1515, 16'h1515, 16'h0808, 16'h0000, 16'h0F0F, 16'h0008};

    reset = 1'b1; ac97_ready = 1'b0; volume = 5'd10; source = 1'b0;
    out_left = 20'hABCDE; out_right = 20'h54321;
    left_in_data = 20'h12345; right_in_data = 20'h6789A;
`ifdef AC97_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk_zero_outputs("reset");

    // No ready activity: everything holds at reset values.
    repeat (50) @(posedge clock);
    #1;
    chk_zero_outputs("idle");

    // Ticks 1..16: settle time, no commands.
    for (int i = 1; i <= 16; i++) begin
      do_tick(3);
      chk("wait_cvalid", {31'd0, command_valid}, 32'd0);
      chk("wait_lvalid", {31'd0, left_valid}, 32'd0);
      chk("wait_idone", {31'd0, init_done}, 32'd0);
      if (i == 1) begin
        chk("ldata", {12'd0, left_data}, 32'h000ABCDE);
        chk("rdata", {12'd0, right_data}, 32'h00054321);
        chk("inl", {12'd0, in_left}, 32'h00012345);
        chk("inr", {12'd0, in_right}, 32'h0006789A);
        out_left = 20'h11111; left_in_data = 20'h22222;
        repeat (3) @(posedge clock);
        #1;
        chk("ldata_hold", {12'd0, left_data}, 32'h000ABCDE);
        chk("inl_hold", {12'd0, in_left}, 32'h00012345);
      end
      if (i == 2) begin
        chk("ldata_next", {12'd0, left_data}, 32'h00011111);
        chk("inl_next", {12'd0, in_left}, 32'h00022222);
      end
    end

    // Ticks 17..22: init list.
    for (int k = 0; k < 6; k++) begin
      do_tick(3);
      chk_cmd("init", init_addr[k], init_data[k]);
      chk("init_idone", {31'd0, init_done}, (k == 5) ? 32'd1 : 32'd0);
      chk("init_lvalid", {31'd0, left_valid}, (k == 5) ? 32'd1 : 32'd0);
      chk("init_rvalid", {31'd0, right_valid}, (k == 5) ? 32'd1 : 32'd0);
    end

    // Refresh: volume extremes and source change.
    volume = 5'd31;
    do_tick(3); chk_cmd("vol31_master", 8'h02, 16'h0000);
    volume = 5'd0;
    do_tick(3); chk_cmd("vol0_hp", 8'h04, 16'h8000);
    source = 1'b1;
    do_tick(3); chk_cmd("pcm", 8'h18, 16'h0808);
    do_tick(3); chk_cmd("src_line", 8'h1A, 16'h0404);
    do_tick(3); chk_cmd("gain", 8'h1C, 16'h0F0F);
    do_tick(3); chk_cmd("mic", 8'h0E, 16'h0008);
    do_tick(3); chk_cmd("vol0_master", 8'h02, 16'h8000);
    // Long ready-high: a single strobe only.
    volume = 5'd10;
    do_tick(100); chk_cmd("long_ready_hp", 8'h04, 16'h1515);

    // Reset at init cmd 3, with a ready level held across the release.
    reset = 1'b1;
    #1;
    chk("midreset_idone_async", {31'd0, init_done}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_zero_outputs("reset2");
    for (int i = 1; i <= 16; i++) begin
      do_tick(3);
      chk("wait2_cvalid", {31'd0, command_valid}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      do_tick(3);
      chk_cmd("init2", init_addr[k], (k == 3) ? 16'h0404 : init_data[k]);
    end
    #2 reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    ac97_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    nstb = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (sample_strobe) nstb++;
    end
    chk("lost_tick", nstb, 0);
    ac97_ready = 1'b0;
    repeat (5) @(posedge clock);
    for (int i = 1; i <= 16; i++) begin
      do_tick(3);
      chk("wait3_cvalid", {31'd0, command_valid}, 32'd0);
    end
    do_tick(3); chk_cmd("reinit_cmd0", 8'h02, 16'h1515);

`ifdef AC97_LOOPBACK_EN
    loopback = 1'b1;
    out_left = 20'h0F0F0; left_in_data = 20'h3C3C3; right_in_data = 20'h5A5A5;
    do_tick(3);
    chk("loop_l", {12'd0, left_data}, 32'h0003C3C3);
    chk("loop_r", {12'd0, right_data}, 32'h0005A5A5);
    left_in_data = 20'h77777;
    do_tick(3);
    chk("loop_l2", {12'd0, left_data}, 32'h00077777);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
